// File: rtl/mux2_select_sequencer_if.sv
// rtl/mux2_select_sequencer_if.sv - control/status bundle between a sequencer user and mux2_select_sequencer
// Signals:
//   en, mode, dwell0, dwell1 : run request and dwell program, driven by the user (master)
//   s0, switch_pulse         : registered Mux2 select and one-cycle select-change flag
//   busy, done, cnt          : run status and cycles remaining in the current dwell
interface mux2_select_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             mode;
  logic [CNT_W-1:0] dwell0;
  logic [CNT_W-1:0] dwell1;
  logic             s0;
  logic             switch_pulse;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] cnt;

  modport master (
    output en, mode, dwell0, dwell1,
    input  s0, switch_pulse, busy, done, cnt
  );

  modport slave (
    input  en, mode, dwell0, dwell1,
    output s0, switch_pulse, busy, done, cnt
  );
endinterface

// File: rtl/mux2_select_sequencer.sv
// rtl/mux2_select_sequencer.sv - dwell-programmable S0 select generator for the upstream Mux2 stage
// Ports:
//   i_clk   : rising-edge clock
//   i_rst_n : asynchronous active-low reset
//   bus     : slave side of mux2_select_sequencer_if (en/mode/dwell in, s0/switch/busy/done/cnt out)
module mux2_select_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  mux2_select_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD0 = 2'd1,
    ST_HOLD1 = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_s0;
  logic             r_switch;
  logic             r_busy;
  logic             r_done;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_s0_nxt;
  logic             w_switch_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;

  // A programmed dwell of 0 behaves like 1, so the load value is max(d,1)-1.
  logic [CNT_W-1:0] w_load0;
  logic [CNT_W-1:0] w_load1;
  assign w_load0 = (bus.dwell0 == '0) ? '0 : bus.dwell0 - CNT_W'(1);
  assign w_load1 = (bus.dwell1 == '0) ? '0 : bus.dwell1 - CNT_W'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_s0     <= 1'b0;
      r_switch <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_s0     <= w_s0_nxt;
      r_switch <= w_switch_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  // Next state and next registered outputs. Everything defaults to the IDLE
  // view; dropping en in any state lands here, which gives abort its
  // priority over dwell expiry and suppresses any switch pulse.
  always_comb begin
    w_state_nxt  = ST_IDLE;
    w_cnt_nxt    = '0;
    w_s0_nxt     = 1'b0;
    w_switch_nxt = 1'b0;
    w_busy_nxt   = 1'b0;
    w_done_nxt   = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (bus.en) begin
          w_state_nxt = ST_HOLD0;
          w_cnt_nxt   = w_load0;
          w_busy_nxt  = 1'b1;
        end
      end

      ST_HOLD0: begin
        if (bus.en) begin
          w_busy_nxt = 1'b1;
          if (r_cnt != '0) begin
            w_state_nxt = ST_HOLD0;
            w_cnt_nxt   = r_cnt - CNT_W'(1);
          end else begin
            w_state_nxt  = ST_HOLD1;
            w_cnt_nxt    = w_load1;
            w_s0_nxt     = 1'b1;
            w_switch_nxt = 1'b1;
          end
        end
      end

      ST_HOLD1: begin
        if (bus.en) begin
          if (r_cnt != '0) begin
            w_state_nxt = ST_HOLD1;
            w_cnt_nxt   = r_cnt - CNT_W'(1);
            w_s0_nxt    = 1'b1;
            w_busy_nxt  = 1'b1;
          end else if (!bus.mode) begin
            w_state_nxt  = ST_HOLD0;
            w_cnt_nxt    = w_load0;
            w_switch_nxt = 1'b1;
            w_busy_nxt   = 1'b1;
          end else begin
            // Single pass finished: select returns to I0 without a switch flag.
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
          end
        end
      end

      ST_DONE: begin
        // Holding en high parks here, so a new pass needs en to drop first.
        if (bus.en) begin
          w_state_nxt = ST_DONE;
          w_done_nxt  = 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.s0           = r_s0;
  assign bus.switch_pulse = r_switch;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.cnt          = r_cnt;

endmodule
